fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The module SHALL have parameter DEPTH, default 2, the instruction queue depth (power of two, 2..8).
REQ-003 The module SHALL have port clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-005 The module SHALL have port start_i  in  1  fetch enable; low means no new requests are issued.
REQ-006 The module SHALL have port stall_i  in  1  downstream (IF/ID) not ready; the head is held.
REQ-007 The module SHALL have port redirect_i  in  1  branch/jump taken; flush and refetch.
REQ-008 The module SHALL have port redirect_pc_i  in  32  redirect target.
REQ-009 The module SHALL have port imem_req_o  out  1  instruction memory request.
REQ-010 The module SHALL have port imem_addr_o  out  32  request address, word aligned.
REQ-011 The module SHALL have port imem_ack_i  in  1  request complete; imem_data_i valid this cycle.
REQ-012 The module SHALL have port imem_data_i  in  32  instruction word.
REQ-013 The module SHALL have port valid_o  out  1  queue head valid.
REQ-014 The module SHALL have port pc_o  out  32  queue head address.
REQ-015 The module SHALL have port instr_o  out  32  queue head instruction.

Function
REQ-016 The unit SHALL keep at most one outstanding request; imem_addr_o stays stable from req assertion until ack.
REQ-017 An ack in the same cycle as the req (zero-wait memory) SHALL be accepted, giving one instruction per cycle.
REQ-018 A new request SHALL issue only if start_i=1 and (registered count + outstanding) < DEPTH.
REQ-019 Each accepted ack SHALL push {addr, data} into the queue and advance the fetch PC by 4; the PC wraps modulo 2^32.
REQ-020 The head SHALL pop on valid_o=1 && stall_i=0; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-021 The FSM SHALL have states IDLE (no request), FETCH (request out), HOLD (queue full or start_i=0, none out) and DRAIN (discarding a stale request).
REQ-022 Transitions: IDLE->FETCH on issue; FETCH->FETCH on ack with reissue; FETCH->HOLD on ack without issue; HOLD->FETCH when space; any->IDLE when start_i=0 and nothing is outstanding.
REQ-023 redirect_i SHALL take priority over stall and pop: flush the queue the same cycle (valid_o=0 next cycle), load fetch PC = {redirect_pc_i[31:2],2'b00}.
REQ-024 On redirect with a request outstanding and not acked that cycle, the unit SHALL enter DRAIN, keep the old address, and discard the data on ack; it then issues the redirect target.
REQ-025 An ack coinciding with redirect SHALL be discarded; the redirect target SHALL be requested the next cycle.
REQ-026 A redirect during DRAIN SHALL update the pending target only; the last redirect wins.

Reset
REQ-027 On rst_i=1 at a clock edge: fetch PC=RESET_PC, queue empty, state IDLE, imem_req_o=0, imem_addr_o=RESET_PC, valid_o=0, pc_o=0, instr_o=0.
REQ-028 Reset mid-transaction SHALL abandon the outstanding request; an ack arriving in the first cycle after reset SHALL be ignored.

Configuration
REQ-029 With FETCH_PERF_CNT_EN defined, the unit SHALL add output perf_stall_cnt_o (32 bits), counting cycles with valid_o=1 && stall_i=1, reset to 0, saturating at all-ones.
REQ-030 Without FETCH_PERF_CNT_EN, the port and counter SHALL be absent, and behaviour SHALL be otherwise identical.

Structure
REQ-031 The fetch FSM state enum, the PC increment constant 4 and the NOP encoding 32'h0000_0013 SHALL live in a shared package, cpu_pkg.
REQ-032 The queue SHALL be one sub-module, fetch_queue (sync FIFO, DEPTH entries of 64 bits, flush input); the FSM and PC logic stay in fetch_unit.

Verification
REQ-033 Reset, start_i=1, zero-wait memory: addresses 0,4,8,12 on consecutive cycles; valid_o high from cycle 2.
REQ-034 stall_i=1 for 5 cycles with DEPTH=2: the queue fills, imem_req_o drops, the head stays pc_o=0; on release, ordered delivery with no loss or duplicates.
REQ-035 Ack latency 3, redirect to 0x100 in the second wait cycle: the stale word is discarded, the next request is 0x100, and the first valid_o shows pc_o=0x100.
REQ-036 Redirect to 0x203 coinciding with an ack: the acked word is dropped and the request address is 0x200.
REQ-037 rst_i asserted while a request is outstanding: the next-cycle ack is ignored, and fetch restarts at RESET_PC with valid_o=0.
REQ-038 With FETCH_PERF_CNT_EN, 7 stalled-valid cycles give perf_stall_cnt_o=7.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch FSM states, PC step and NOP encoding
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN
    } fetch_state_t;

    localparam logic [31:0] PC_INCR   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sync FIFO of {pc, instr} entries with single-cycle flush
module fetch_queue #(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          s_tvalid,
    input  logic [63:0]   s_tdata,
    input  logic          m_tready,
    output logic          m_tvalid,
    output logic [63:0]   m_tdata,
    output logic [CW-1:0] count
);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign push     = s_tvalid && !flush && (count != CW'(DEPTH));
    assign pop      = m_tready && !flush && (count != '0);
    assign m_tvalid = (count != '0);
    // Empty queue presents zeros so the head fields are clean after reset/flush
    assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with queue; FETCH_PERF_CNT_EN adds a stall counter
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q;
    logic [31:0]   addr_q;
    logic [31:0]   redirect_tgt;
    logic [31:0]   issue_addr;
    logic          outstanding;
    logic          push;
    logic          pop;
    logic          issue;
    logic          space;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic          head_valid;
    logic [63:0]   head;

    assign redirect_tgt = align_word(redirect_pc_i);
    assign outstanding  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign push         = (state_q == ST_FETCH) && imem_ack_i && !redirect_i;
    assign pop          = head_valid && !stall_i && !redirect_i;
    // Occupancy once this edge settles; a flush empties the queue outright
    assign count_after  = redirect_i ? '0 : count + CW'(push) - CW'(pop);
    assign space        = count_after < CW'(DEPTH);
    assign issue_addr   = redirect_i ? redirect_tgt : pc_q;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        if (outstanding && !imem_ack_i) begin
            if (redirect_i) begin
                state_d = ST_DRAIN;
            end
        end else if (start_i && space) begin
            issue   = 1'b1;
            state_d = ST_FETCH;
        end else begin
            state_d = start_i ? ST_HOLD : ST_IDLE;
        end
    end

    // pc_q holds the next address to request; addr_q holds the one on the bus
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (issue) begin
                addr_q <= issue_addr;
                pc_q   <= issue_addr + PC_INCR;
            end else if (redirect_i) begin
                pc_q <= redirect_tgt;
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk_i),
        .rst      (rst_i),
        .flush    (redirect_i),
        .s_tvalid (push),
        .s_tdata  ({addr_q, imem_data_i}),
        .m_tready (pop),
        .m_tvalid (head_valid),
        .m_tdata  (head),
        .count    (count)
    );

    assign imem_req_o  = outstanding;
    assign imem_addr_o = addr_q;
    assign valid_o     = head_valid;
    assign pc_o        = head[63:32];
    assign instr_o     = head[31:0];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_cnt_o <= '0;
        end else if (head_valid && stall_i && (perf_stall_cnt_o != '1)) begin
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a latency-configurable memory
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_o;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_pops = 0;
    int          mem_lat = 0;
    int          wcnt = 0;
    logic        stray_ack = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] ack_addrs[$];
    logic [31:0] exp_e;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack),
        .imem_data_i   (imem_data),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .instr_o       (instr_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic fill_exp(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(base + 32'(4 * i));
        end
    endtask

    task automatic do_reset(input int lat);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        mem_lat = lat;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        ack_addrs.delete();
        n_pops = 0;
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int k = 0;
        while (!valid_o && k < limit) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(valid_o), 32'd1);
    endtask

    // Memory responds 2 time units after each edge; mem_lat wait cycles before ack
    always @(posedge clk) begin
        #2;
        if (stray_ack) begin
            imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF; wcnt = 0;
        end else if (imem_req_o && wcnt >= mem_lat) begin
            imem_ack = 1'b1; imem_data = mem_word(imem_addr_o); wcnt = 0;
        end else if (imem_req_o) begin
            imem_ack = 1'b0; wcnt++;
        end else begin
            imem_ack = 1'b0; wcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req_o && imem_ack) begin
                ack_addrs.push_back(imem_addr_o);
            end
            if (valid_o && !stall && !redirect) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    check_eq("sb_extra_pop", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_e = exp_q.pop_front();
                    check_eq("sb_pc", pc_o, exp_e);
                    check_eq("sb_instr", instr_o, mem_word(exp_e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Zero-wait streaming from reset
        do_reset(0); fill_exp(32'h0); start = 1'b1;
        @(negedge clk);
        check_eq("rst_req", 32'(imem_req_o), 32'd0);
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_addr", imem_addr_o, 32'h0);
        check_eq("rst_pc", pc_o, 32'h0);
        check_eq("rst_instr", instr_o, 32'h0);
        @(negedge clk);
        check_eq("s1_req_c1", 32'(imem_req_o), 32'd1);
        check_eq("s1_addr_c1", imem_addr_o, 32'h0);
        check_eq("s1_valid_c1", 32'(valid_o), 32'd0);
        @(negedge clk);
        check_eq("s1_valid_c2", 32'(valid_o), 32'd1);
        check_eq("s1_addr_c2", imem_addr_o, 32'h4);
        @(negedge clk);
        check_eq("s1_addr_c3", imem_addr_o, 32'h8);
        @(negedge clk);
        check_eq("s1_addr_c4", imem_addr_o, 32'hC);
        repeat (4) @(negedge clk);

        // Stall fills the queue, then ordered release
        do_reset(0); fill_exp(32'h0); stall = 1'b1; start = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("s2_head_c2", pc_o, 32'h0);
        @(negedge clk);
        check_eq("s2_head_c3", pc_o, 32'h0);
        @(negedge clk);
        check_eq("s2_head_c4", pc_o, 32'h0);
        check_eq("s2_req_drop", 32'(imem_req_o), 32'd0);
        check_eq("s2_valid_full", 32'(valid_o), 32'd1);
        @(posedge clk); #1; stall = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        check_eq("s2_pops", 32'(n_pops), 32'd10);

        // Redirect while a slow request is outstanding
        do_reset(3); fill_exp(32'h0); start = 1'b1;
        repeat (2) @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 32'h100; fill_exp(32'h100);
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk);
        check_eq("s3_drain_req", 32'(imem_req_o), 32'd1);
        check_eq("s3_drain_addr", imem_addr_o, 32'h0);
        check_eq("s3_flush_valid", 32'(valid_o), 32'd0);
        wait_valid("s3_valid_seen", 20);
        check_eq("s3_first_pc", pc_o, 32'h100);
        check_eq("s3_ack_count", 32'(ack_addrs.size()), 32'd2);
        if (ack_addrs.size() >= 2) begin
            check_eq("s3_next_req", ack_addrs[1], 32'h100);
        end
        repeat (3) @(negedge clk);

        // Redirect coinciding with an ack, unaligned target
        do_reset(0); fill_exp(32'h0); start = 1'b1;
        repeat (3) @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 32'h203; fill_exp(32'h200);
        @(negedge clk);
        check_eq("s4_ack_coincide", 32'(imem_ack), 32'd1);
        check_eq("s4_acked_addr", imem_addr_o, 32'h8);
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk);
        check_eq("s4_flush_valid", 32'(valid_o), 32'd0);
        check_eq("s4_req", 32'(imem_req_o), 32'd1);
        check_eq("s4_addr", imem_addr_o, 32'h200);
        repeat (4) @(negedge clk);

        // Reset during an outstanding request, stray ack right after
        do_reset(3); fill_exp(32'h0); start = 1'b1;
        repeat (6) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; stray_ack = 1'b1; ack_addrs.delete(); fill_exp(32'h0);
        @(negedge clk);
        check_eq("s5_stray_ack", 32'(imem_ack), 32'd1);
        check_eq("s5_valid", 32'(valid_o), 32'd0);
        check_eq("s5_req", 32'(imem_req_o), 32'd0);
        check_eq("s5_addr", imem_addr_o, 32'h0);
        @(posedge clk); #1; stray_ack = 1'b0;
        @(negedge clk);
        wait_valid("s5_valid_seen", 20);
        check_eq("s5_first_pc", pc_o, 32'h0);
        check_eq("s5_first_instr", instr_o, mem_word(32'h0));
        if (ack_addrs.size() >= 1) begin
            check_eq("s5_restart_addr", ack_addrs[0], 32'h0);
        end
        repeat (3) @(negedge clk);

`ifdef FETCH_PERF_CNT_EN
        // Seven stalled-valid cycles
        do_reset(0); fill_exp(32'h0); start = 1'b1; stall = 1'b1;
        @(negedge clk);
        check_eq("s6_perf_rst", perf_stall_cnt_o, 32'd0);
        wait_valid("s6_valid_seen", 10);
        repeat (7) @(posedge clk);
        #1; stall = 1'b0;
        @(negedge clk);
        check_eq("s6_perf_cnt", perf_stall_cnt_o, 32'd7);
        repeat (3) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
